// File: rtl/idma_obi_read_arb_pkg.sv
// Shared types for the iDMA OBI read arbiter: requester index, lock state and fill count.
package idma_obi_read_arb_pkg;

    localparam int unsigned IDX_W_MAX = 8;
    localparam int unsigned CNT_W_MAX = 9;

    typedef logic [IDX_W_MAX-1:0] req_idx_t;
    typedef logic [CNT_W_MAX-1:0] cnt_t;

    typedef struct packed {
        logic     locked;
        req_idx_t lock_idx;
    } lock_state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned req_idx_bits(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/idma_obi_read_arb_idfifo.sv
// In-order FIFO of granted requester indices; the head names the owner of the next R beat.
module idma_obi_read_arb_idfifo
    import idma_obi_read_arb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  req_idx_t data_i,
    input  logic     pop_i,
    output req_idx_t data_o,
    output logic     full_o,
    output logic     empty_o,
    output cnt_t     count_o
);

    localparam int unsigned     PtrW    = req_idx_bits(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    req_idx_t        mem_r [Depth];
    logic [PtrW-1:0] wr_ptr_r;
    logic [PtrW-1:0] rd_ptr_r;
    cnt_t            count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? {PtrW{1'b0}} : p + PtrW'(1);
    endfunction

    assign full_o    = (count_r == cnt_t'(Depth));
    assign empty_o   = (count_r == {CNT_W_MAX{1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign data_o    = mem_r[rd_ptr_r];
    assign count_o   = count_r;

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_r[i] <= {IDX_W_MAX{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointers and fill count; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CNT_W_MAX{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + cnt_t'(1);
            end else if (!push_ok_s && pop_ok_s) begin
                count_r <= count_r - cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/idma_obi_read_arbiter.sv
// Shares one OBI read manager port among NumReq requesters; responses are routed via an ID FIFO.
// Define IDMA_OBI_READ_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module idma_obi_read_arbiter
    import idma_obi_read_arb_pkg::*;
#(
    parameter  int unsigned NumReq         = 4,
    parameter  int unsigned MaxOutstanding = 4,
    parameter  int unsigned AddrWidth      = 32,
    parameter  int unsigned DataWidth      = 32,
    localparam int unsigned StrbWidth      = DataWidth / 8,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumReq-1:0][StrbWidth-1:0]  be_i,
    output logic [NumReq-1:0]                 gnt_o,
    output logic [NumReq-1:0]                 rvalid_o,
    input  logic [NumReq-1:0]                 rready_i,
    output logic [DataWidth-1:0]              rdata_o,
    output logic                              err_o,
    output logic                              obi_req_o,
    output logic [AddrWidth-1:0]              obi_addr_o,
    output logic [StrbWidth-1:0]              obi_be_o,
    input  logic                              obi_gnt_i,
    input  logic                              obi_rvalid_i,
    input  logic [DataWidth-1:0]              obi_rdata_i,
    input  logic                              obi_err_i,
    output logic                              obi_rready_o,
    output logic [CntWidth-1:0]               outstanding_o,
    output logic                              spurious_o
);

    localparam int unsigned IdxW = req_idx_bits(NumReq);
    typedef logic [IdxW-1:0] idx_t;

    lock_state_t lock_r;
    idx_t        pick_s;
    idx_t        win_s;
    idx_t        head_idx_s;
    req_idx_t    head_s;
    cnt_t        count_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        a_hs_s;
    logic        pop_s;
    logic        unused_s;

`ifdef IDMA_OBI_READ_ARB_FIXED_PRIO_EN
    // Fixed priority: scanning downwards leaves the lowest asserted index.
    always_comb begin
        pick_s = {IdxW{1'b0}};
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pick_s = IdxW'(i);
            end else begin
                pick_s = pick_s;
            end
        end
    end
`else
    localparam idx_t LastIdx = IdxW'(NumReq - 1);
    idx_t rr_ptr_r;

    // Round-robin: first asserted request at or after rr_ptr, wrapping around.
    always_comb begin
        logic        found;
        int unsigned cand;
        pick_s = rr_ptr_r;
        found  = 1'b0;
        cand   = 32'd0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(rr_ptr_r) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end else begin
                cand = cand;
            end
            if (!found && req_i[cand[IdxW-1:0]]) begin
                pick_s = cand[IdxW-1:0];
                found  = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // Pointer moves past the winner on every accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r <= {IdxW{1'b0}};
        end else if (a_hs_s) begin
            rr_ptr_r <= (win_s == LastIdx) ? {IdxW{1'b0}} : win_s + IdxW'(1);
        end
    end
`endif

    // A stalled request keeps its requester selected until granted.
    always_comb begin
        if (lock_r.locked) begin
            win_s = lock_r.lock_idx[IdxW-1:0];
        end else begin
            win_s = pick_s;
        end
    end

    assign obi_req_o  = rst_ni & (|req_i) & ~fifo_full_s;
    assign obi_addr_o = addr_i[win_s];
    assign obi_be_o   = be_i[win_s];
    assign a_hs_s     = obi_req_o & obi_gnt_i;

    // Grant fan-out to the current winner.
    always_comb begin
        gnt_o = {NumReq{1'b0}};
        if (a_hs_s) begin
            gnt_o[win_s] = 1'b1;
        end else begin
            gnt_o = {NumReq{1'b0}};
        end
    end

    // Lock on a stalled request, release on grant; a full FIFO leaves the lock untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_r.locked   <= 1'b0;
            lock_r.lock_idx <= {IDX_W_MAX{1'b0}};
        end else if (a_hs_s) begin
            lock_r.locked <= 1'b0;
        end else if (obi_req_o) begin
            lock_r.locked   <= 1'b1;
            lock_r.lock_idx <= req_idx_t'(win_s);
        end
    end

    idma_obi_read_arb_idfifo #(
        .Depth (MaxOutstanding)
    ) i_idfifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (a_hs_s),
        .data_i  (req_idx_t'(win_s)),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (count_s)
    );

    assign head_idx_s = head_s[IdxW-1:0];

    // R routing: the FIFO head owns the beat; with nothing in flight the beat is sunk and flagged.
    always_comb begin
        rvalid_o     = {NumReq{1'b0}};
        obi_rready_o = 1'b0;
        spurious_o   = 1'b0;
        pop_s        = 1'b0;
        if (!rst_ni) begin
            obi_rready_o = 1'b0;
        end else if (!fifo_empty_s) begin
            rvalid_o[head_idx_s] = obi_rvalid_i;
            obi_rready_o         = rready_i[head_idx_s];
            pop_s                = obi_rvalid_i & rready_i[head_idx_s];
        end else begin
            obi_rready_o = obi_rvalid_i;
            spurious_o   = obi_rvalid_i;
        end
    end

    assign rdata_o       = obi_rdata_i;
    assign err_o         = obi_err_i;
    assign outstanding_o = count_s[CntWidth-1:0];

    // Package-width fields are wider than this configuration needs.
    assign unused_s = ^{head_s, lock_r.lock_idx, count_s};

endmodule

// File: tb/tb_idma_obi_read_arbiter.sv
// Bench for idma_obi_read_arbiter: directed table, corner sequences, then random traffic vs a queue model.
module tb_idma_obi_read_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned MO = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic                    clk;
    logic                    rst_ni;
    logic [NR-1:0]           req_i, gnt_o, rvalid_o, rready_i;
    logic [NR-1:0][AW-1:0]   addr_i;
    logic [NR-1:0][SW-1:0]   be_i;
    logic [DW-1:0]           rdata_o, obi_rdata_i;
    logic                    err_o, obi_err_i;
    logic                    obi_req_o, obi_gnt_i, obi_rvalid_i, obi_rready_o, spurious_o;
    logic [AW-1:0]           obi_addr_o;
    logic [SW-1:0]           obi_be_o;
    logic [2:0]              outstanding_o;

    idma_obi_read_arbiter #(
        .NumReq(NR), .MaxOutstanding(MO), .AddrWidth(AW), .DataWidth(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .be_i(be_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
        .err_o(err_o), .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_be_o(obi_be_o),
        .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .obi_err_i(obi_err_i), .obi_rready_o(obi_rready_o), .outstanding_o(outstanding_o),
        .spurious_o(spurious_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of owners in response order, plus arbitration state.
    int            id_q[$];
    int            m_ptr      = 0;
    bit            m_locked   = 1'b0;
    int            m_lock_idx = 0;
    logic [NR-1:0] m_gnt;

    // Snapshots of DUT outputs taken mid-cycle.
    logic          s_req, s_rready, s_spur;
    logic [AW-1:0] s_addr;
    logic [NR-1:0] s_gnt, s_rvalid;
    logic [2:0]    s_out;

    typedef struct {
        logic [NR-1:0] req;
        logic          gnt;
        logic          rv;
        logic [NR-1:0] rr;
        logic          e_req;
        int            e_w;
        logic [NR-1:0] e_gnt;
        logic [NR-1:0] e_rvalid;
        logic          e_rready;
        logic          e_spur;
        int            e_out;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        id_q.delete();
        m_ptr      = 0;
        m_locked   = 1'b0;
        m_lock_idx = 0;
    endtask

    // One clock cycle: drive, sample at the falling edge, compare to model, advance model.
    task automatic step(input logic [NR-1:0] req, input logic gnt, input logic rv, input logic [NR-1:0] rr);
        int            n, w, h;
        logic          e_req, e_rready, e_spur;
        logic [NR-1:0] e_gnt, e_rvalid;
        req_i        = req;
        obi_gnt_i    = gnt;
        obi_rvalid_i = rv;
        rready_i     = rr;
        obi_rdata_i  = $urandom;
        obi_err_i    = 1'($urandom_range(0, 1));
        #4;
        s_req = obi_req_o; s_addr = obi_addr_o; s_gnt = gnt_o; s_rvalid = rvalid_o;
        s_rready = obi_rready_o; s_spur = spurious_o; s_out = outstanding_o;

        n     = id_q.size();
        e_req = (req != '0) && (n < MO);
        w     = 0;
        h     = 0;
        if (m_locked) begin
            w = m_lock_idx;
        end else begin
`ifdef IDMA_OBI_READ_ARB_FIXED_PRIO_EN
            for (int k = NR - 1; k >= 0; k--) if (req[k]) w = k;
`else
            for (int k = NR - 1; k >= 0; k--) if (req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
`endif
        end
        e_gnt = '0;
        if (e_req && gnt) e_gnt[w] = 1'b1;
        e_rvalid = '0;
        e_spur   = 1'b0;
        if (n > 0) begin
            h = id_q[0];
            if (rv) e_rvalid[h] = 1'b1;
            e_rready = rr[h];
        end else begin
            e_spur   = rv;
            e_rready = rv;
        end

        check("obi_req", 64'(s_req), 64'(e_req));
        if (e_req) begin
            check("obi_addr", 64'(s_addr), 64'(addr_i[w]));
            check("obi_be", 64'(obi_be_o), 64'(be_i[w]));
        end
        check("gnt", 64'(s_gnt), 64'(e_gnt));
        check("rvalid", 64'(s_rvalid), 64'(e_rvalid));
        check("obi_rready", 64'(s_rready), 64'(e_rready));
        check("spurious", 64'(s_spur), 64'(e_spur));
        check("outstanding", 64'(s_out), 64'(n));
        check("rdata", 64'(rdata_o), 64'(obi_rdata_i));
        check("err", 64'(err_o), 64'(obi_err_i));

        m_gnt = e_gnt;
        if (n > 0 && rv && rr[h]) void'(id_q.pop_front());
        if (e_req && gnt) begin
            id_q.push_back(w);
            m_locked = 1'b0;
            m_ptr    = (w + 1) % NR;
        end else if (e_req) begin
            m_locked   = 1'b1;
            m_lock_idx = w;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NR-1:0] pend;
        //         req      g     rv    rr       e_req e_w e_gnt    e_rvalid e_rdy e_sp e_out
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 1'b0, 0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 0, 4'b0001, 4'b0000, 1'b0, 1'b0, 0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1, 4'b0010, 4'b0001, 1'b1, 1'b0, 1};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 2, 4'b0100, 4'b0010, 1'b1, 1'b0, 1};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 3, 4'b1000, 4'b0100, 1'b1, 1'b0, 1};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 0, 4'b0001, 4'b1000, 1'b1, 1'b0, 1};
        tbl[6]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1};
        tbl[7]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 0};
        tbl[8]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2, 4'b0100, 4'b0000, 1'b0, 1'b0, 0};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1};
        tbl[10] = '{4'b0011, 1'b1, 1'b1, 4'b1011, 1'b1, 0, 4'b0001, 4'b0100, 1'b0, 1'b0, 1};
        tbl[11] = '{4'b0010, 1'b1, 1'b1, 4'b0100, 1'b1, 1, 4'b0010, 4'b0100, 1'b1, 1'b0, 2};
        tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 0, 4'b0000, 4'b0001, 1'b1, 1'b0, 2};
        tbl[13] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1};
        tbl[14] = '{4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 0, 4'b0000, 4'b0010, 1'b1, 1'b0, 1};

        for (int i = 0; i < NR; i++) begin
            addr_i[i] = 32'h1000_0000 + 32'(i * 16);
            be_i[i]   = SW'(1 << i);
        end
        // Reset held with every input active: all outputs must stay quiet.
        rst_ni = 1'b0; req_i = '1; obi_gnt_i = 1'b1; obi_rvalid_i = 1'b1; rready_i = '1;
        obi_rdata_i = '0; obi_err_i = 1'b0;
        #2;
        check("rst_obi_req", 64'(obi_req_o), 64'(0));
        check("rst_gnt", 64'(gnt_o), 64'(0));
        check("rst_rvalid", 64'(rvalid_o), 64'(0));
        check("rst_obi_rready", 64'(obi_rready_o), 64'(0));
        check("rst_outstanding", 64'(outstanding_o), 64'(0));
        check("rst_spurious", 64'(spurious_o), 64'(0));
        req_i = '0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; rready_i = '0;
        #10 rst_ni = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Directed table: round-robin order, in-order routing, spurious beat, back-pressure.
        for (int k = 0; k < 15; k++) begin
            step(tbl[k].req, tbl[k].gnt, tbl[k].rv, tbl[k].rr);
            check($sformatf("tbl%0d_req", k), 64'(s_req), 64'(tbl[k].e_req));
            if (tbl[k].e_req) check($sformatf("tbl%0d_addr", k), 64'(s_addr), 64'(addr_i[tbl[k].e_w]));
            check($sformatf("tbl%0d_gnt", k), 64'(s_gnt), 64'(tbl[k].e_gnt));
            check($sformatf("tbl%0d_rvalid", k), 64'(s_rvalid), 64'(tbl[k].e_rvalid));
            check($sformatf("tbl%0d_rready", k), 64'(s_rready), 64'(tbl[k].e_rready));
            check($sformatf("tbl%0d_spur", k), 64'(s_spur), 64'(tbl[k].e_spur));
            check($sformatf("tbl%0d_out", k), 64'(s_out), 64'(tbl[k].e_out));
        end

        // Lock: requester 1 stalls three cycles while requester 0 joins.
        step(4'b0010, 1'b0, 1'b0, 4'b0000);
        check("lock_addr0", 64'(s_addr), 64'(addr_i[1]));
        step(4'b0011, 1'b0, 1'b0, 4'b0000);
        check("lock_addr1", 64'(s_addr), 64'(addr_i[1]));
        step(4'b0011, 1'b0, 1'b0, 4'b0000);
        check("lock_addr2", 64'(s_addr), 64'(addr_i[1]));
        step(4'b0011, 1'b1, 1'b0, 4'b0000);
        check("lock_gnt1", 64'(s_gnt), 64'(4'b0010));
        step(4'b0001, 1'b1, 1'b0, 4'b0000);
        check("lock_then_gnt0", 64'(s_gnt), 64'(4'b0001));

        // Full: two more grants fill the FIFO; a pop in the same cycle still blocks the request.
        step(4'b1111, 1'b1, 1'b0, 4'b0000);
        step(4'b1111, 1'b1, 1'b0, 4'b0000);
        step(4'b1111, 1'b1, 1'b0, 4'b0000);
        check("full_out", 64'(s_out), 64'(4));
        check("full_req", 64'(s_req), 64'(0));
        step(4'b1111, 1'b0, 1'b1, 4'b1111);
        check("full_pop_req", 64'(s_req), 64'(0));
        step(4'b1111, 1'b0, 1'b0, 4'b0000);
        check("after_pop_req", 64'(s_req), 64'(1));
        check("after_pop_out", 64'(s_out), 64'(3));

        // Reset with three in flight: count clears at once, later beat is spurious.
        rst_ni = 1'b0; req_i = '1; obi_gnt_i = 1'b1; obi_rvalid_i = 1'b1; rready_i = '1;
        #1;
        check("midrst_out", 64'(outstanding_o), 64'(0));
        check("midrst_req", 64'(obi_req_o), 64'(0));
        check("midrst_rready", 64'(obi_rready_o), 64'(0));
        check("midrst_rvalid", 64'(rvalid_o), 64'(0));
        model_reset();
        req_i = '0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; rready_i = '0;
        #2 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        check("post_rst_spur", 64'(s_spur), 64'(1));
        check("post_rst_rvalid", 64'(s_rvalid), 64'(0));

        // Random traffic: requests held until granted, beats only while something is in flight.
        pend = '0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    addr_i[i] = $urandom;
                    be_i[i]   = SW'($urandom);
                end
            end
            step(pend, 1'($urandom_range(0, 1)),
                 (id_q.size() > 0) && ($urandom_range(0, 1) == 1), NR'($urandom));
            pend = pend & ~m_gnt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
